// File: rtl/sigmeter_mc.sv
// sigmeter_mc: multi-channel serial-sample frequency / duty / pulse-width meter.
//
// Each valid strobe delivers SW consecutive 1-bit samples per channel (bit 0
// oldest). Per channel the block keeps an IIR-filtered edge count per gate
// window (frequency), an IIR-filtered ones count per window (duty) and the
// last completed high and low run lengths. A registered mux presents one
// value per cycle to downstream readout logic.
//
// Optional feature macro: SIGMETER_MINMAX_EN
//   When defined, per-channel min/max of completed high runs over each gate
//   window are published on window close (sel_q 4 = min_h, 5 = max_h).
//
// Ports:
//   clk      single clock, all logic on posedge
//   rst      synchronous active-high reset
//   s_valid  sample word strobe
//   s_data   NCH*SW samples, channel c at [c*SW +: SW]
//   sel_ch   readout channel (>= NCH reads 0)
//   sel_q    readout quantity: 0 freq, 1 duty, 2 t_high, 3 t_low, 4 min_h, 5 max_h
//   rd_data  selected value, one cycle after sel_ch/sel_q/state
//   upd      one-cycle pulse in the cycle after a gate window closes
module sigmeter_mc #(
  parameter int NCH    = 2,
  parameter int SW     = 32,
  parameter int CW     = 32,
  parameter int GATE   = 31250,
  parameter int AVG_SH = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     s_valid,
  input  logic [NCH*SW-1:0]                        s_data,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] sel_ch,
  input  logic [2:0]                               sel_q,
  output logic [CW-1:0]                            rd_data,
  output logic                                     upd
);

  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW   = (GATE > 1) ? $clog2(GATE) : 1;
  localparam int AW   = CW + AVG_SH + 1;
  localparam logic [CW-1:0] SW_C     = CW'(SW);
  localparam logic [WW-1:0] WIN_LAST = WW'(GATE - 1);

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  // avg(a,b) = (a*(2^K-1) + b + 2^(K-1)) >> K at CW+K+1 bits, truncated.
  function automatic logic [CW-1:0] avg(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [AW-1:0] acc;
    acc = AW'(a) * AW'((1 << AVG_SH) - 1) + AW'(b) + AW'(1 << (AVG_SH - 1));
    return acc[AVG_SH +: CW];
  endfunction

  // Per-channel state
  logic [NCH-1:0] r_prev;
  logic [CW-1:0]  r_run   [NCH];
  logic [CW-1:0]  r_thigh [NCH];
  logic [CW-1:0]  r_tlow  [NCH];
  logic [CW-1:0]  r_freq  [NCH];
  logic [CW-1:0]  r_duty  [NCH];
  logic [CW-1:0]  r_eacc  [NCH];
  logic [CW-1:0]  r_oacc  [NCH];
  logic [WW-1:0]  r_win;
  logic           r_upd;
  logic [CW-1:0]  r_rd;

  // Word-level analysis
  logic [SW:0]    w_ext    [NCH];
  logic [CW-1:0]  w_edges  [NCH];
  logic [CW-1:0]  w_ones   [NCH];
  logic [CW-1:0]  w_hi_len [NCH];
  logic [CW-1:0]  w_lo_len [NCH];
  logic [CW-1:0]  w_last   [NCH];
  logic [NCH-1:0] w_any;
  logic [NCH-1:0] w_hi_vld;
  logic [NCH-1:0] w_lo_vld;
  logic           w_close;
  logic [CW-1:0]  w_rd;

`ifdef SIGMETER_MINMAX_EN
  logic [CW-1:0]  r_hmin  [NCH];
  logic [CW-1:0]  r_hmax  [NCH];
  logic [NCH-1:0] r_hseen;
  logic [CW-1:0]  r_minh  [NCH];
  logic [CW-1:0]  r_maxh  [NCH];
  logic [CW-1:0]  w_wmin  [NCH];
  logic [CW-1:0]  w_wmax  [NCH];
  logic [NCH-1:0] w_wseen;
  logic [CW-1:0]  w_min_all [NCH];
  logic [CW-1:0]  w_max_all [NCH];
`endif

  assign w_close = s_valid && (r_win == WIN_LAST);

  // Scan each word oldest-to-newest. w_ext prepends the previous bit so an
  // edge between the last word and bit 0 is seen at index 0. The first edge
  // closes the run carried in from earlier words; later edges close runs
  // measured from the preceding edge.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_ext[c]    = {s_data[c*SW +: SW], r_prev[c]};
      w_edges[c]  = '0;
      w_ones[c]   = '0;
      w_hi_len[c] = '0;
      w_lo_len[c] = '0;
      w_last[c]   = '0;
      w_any[c]    = 1'b0;
      w_hi_vld[c] = 1'b0;
      w_lo_vld[c] = 1'b0;
`ifdef SIGMETER_MINMAX_EN
      w_wmin[c]   = '1;
      w_wmax[c]   = '0;
      w_wseen[c]  = 1'b0;
`endif
      for (int i = 0; i < SW; i++) begin
        logic [CW-1:0] v_len;
        v_len = '0;
        w_ones[c] = w_ones[c] + CW'(w_ext[c][i+1]);
        if (w_ext[c][i+1] != w_ext[c][i]) begin
          v_len = w_any[c] ? (CW'(i) - w_last[c]) : sat_add(r_run[c], CW'(i));
          w_edges[c] = w_edges[c] + CW'(1);
          if (w_ext[c][i]) begin
            w_hi_len[c] = v_len;
            w_hi_vld[c] = 1'b1;
`ifdef SIGMETER_MINMAX_EN
            w_wseen[c] = 1'b1;
            if (v_len < w_wmin[c]) w_wmin[c] = v_len;
            if (v_len > w_wmax[c]) w_wmax[c] = v_len;
`endif
          end else begin
            w_lo_len[c] = v_len;
            w_lo_vld[c] = 1'b1;
          end
          w_any[c]  = 1'b1;
          w_last[c] = CW'(i);
        end
      end
`ifdef SIGMETER_MINMAX_EN
      w_min_all[c] = (w_wmin[c] < r_hmin[c]) ? w_wmin[c] : r_hmin[c];
      w_max_all[c] = (w_wmax[c] > r_hmax[c]) ? w_wmax[c] : r_hmax[c];
`endif
    end
  end

  // Readout mux; unmatched channel or quantity reads 0
  always_comb begin
    w_rd = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_ch == SELW'(c)) begin
        case (sel_q)
          3'd0:    w_rd = r_freq[c];
          3'd1:    w_rd = r_duty[c];
          3'd2:    w_rd = r_thigh[c];
          3'd3:    w_rd = r_tlow[c];
`ifdef SIGMETER_MINMAX_EN
          3'd4:    w_rd = r_minh[c];
          3'd5:    w_rd = r_maxh[c];
`endif
          default: w_rd = '0;
        endcase
      end
    end
  end

  // Stage p0: state update on valid words, registered readout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win  <= '0;
      r_upd  <= 1'b0;
      r_rd   <= '0;
      r_prev <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_run[c]   <= '0;
        r_thigh[c] <= '0;
        r_tlow[c]  <= '0;
        r_freq[c]  <= '0;
        r_duty[c]  <= '0;
        r_eacc[c]  <= '0;
        r_oacc[c]  <= '0;
`ifdef SIGMETER_MINMAX_EN
        r_hmin[c]  <= '1;
        r_hmax[c]  <= '0;
        r_hseen[c] <= 1'b0;
        r_minh[c]  <= '0;
        r_maxh[c]  <= '0;
`endif
      end
    end else begin
      r_upd <= w_close;
      r_rd  <= w_rd;
      if (s_valid) begin
        r_win <= w_close ? '0 : r_win + WW'(1);
        for (int c = 0; c < NCH; c++) begin
          r_prev[c] <= w_ext[c][SW];
          r_run[c]  <= w_any[c] ? (SW_C - w_last[c]) : sat_add(r_run[c], SW_C);
          if (w_hi_vld[c]) r_thigh[c] <= w_hi_len[c];
          if (w_lo_vld[c]) r_tlow[c]  <= w_lo_len[c];
          if (w_close) begin
            r_freq[c] <= avg(r_freq[c], sat_add(r_eacc[c], w_edges[c]));
            r_duty[c] <= avg(r_duty[c], sat_add(r_oacc[c], w_ones[c]));
            r_eacc[c] <= '0;
            r_oacc[c] <= '0;
          end else begin
            r_eacc[c] <= sat_add(r_eacc[c], w_edges[c]);
            r_oacc[c] <= sat_add(r_oacc[c], w_ones[c]);
          end
`ifdef SIGMETER_MINMAX_EN
          if (w_close) begin
            r_minh[c]  <= (r_hseen[c] || w_wseen[c]) ? w_min_all[c] : '0;
            r_maxh[c]  <= w_max_all[c];
            r_hmin[c]  <= '1;
            r_hmax[c]  <= '0;
            r_hseen[c] <= 1'b0;
          end else begin
            r_hmin[c]  <= w_min_all[c];
            r_hmax[c]  <= w_max_all[c];
            r_hseen[c] <= r_hseen[c] | w_wseen[c];
          end
`endif
        end
      end
    end
  end

  assign rd_data = r_rd;
  assign upd     = r_upd;

endmodule

// File: tb/tb_sigmeter_mc.sv
module tb_sigmeter_mc;
  localparam int NCH  = 3;
  localparam int SW   = 32;
  localparam int CW   = 8;
  localparam int GATE = 4;
  localparam int K    = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [NCH*SW-1:0] s_data;
  logic [1:0]        sel_ch;
  logic [2:0]        sel_q;
  logic [CW-1:0]     rd_data;
  logic              upd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sigmeter_mc #(.NCH(NCH), .SW(SW), .CW(CW), .GATE(GATE), .AVG_SH(K)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
    .sel_ch(sel_ch), .sel_q(sel_q), .rd_data(rd_data), .upd(upd)
  );

  // Behavioural model: bit-serial run tracking with plain integers
  int m_lvl[NCH], m_run[NCH], m_thigh[NCH], m_tlow[NCH];
  int m_freq[NCH], m_duty[NCH], m_eacc[NCH], m_oacc[NCH];
  int m_hmin[NCH], m_hmax[NCH], m_minh[NCH], m_maxh[NCH];
  bit m_hseen[NCH];
  int m_words;
  bit m_close;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_words = 0;
    m_close = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_lvl[c] = 0; m_run[c] = 0; m_thigh[c] = 0; m_tlow[c] = 0;
      m_freq[c] = 0; m_duty[c] = 0; m_eacc[c] = 0; m_oacc[c] = 0;
      m_hmin[c] = 1 << 30; m_hmax[c] = 0; m_hseen[c] = 1'b0;
      m_minh[c] = 0; m_maxh[c] = 0;
    end
  endtask

  task automatic model_word(input logic [NCH*SW-1:0] d);
    int e, o, b, len, ee, oo;
    m_words++;
    m_close = (m_words == GATE);
    if (m_close) m_words = 0;
    for (int c = 0; c < NCH; c++) begin
      e = 0; o = 0;
      for (int i = 0; i < SW; i++) begin
        b = int'(d[c*SW + i]);
        o += b;
        if (b != m_lvl[c]) begin
          e++;
          len = imin(m_run[c], MAXV);
          if (m_lvl[c] == 1) begin
            m_thigh[c] = len;
            m_hseen[c] = 1'b1;
            if (len < m_hmin[c]) m_hmin[c] = len;
            if (len > m_hmax[c]) m_hmax[c] = len;
          end else begin
            m_tlow[c] = len;
          end
          m_lvl[c] = b;
          m_run[c] = 1;
        end else begin
          m_run[c] = imin(m_run[c] + 1, MAXV);
        end
      end
      if (m_close) begin
        ee = imin(m_eacc[c] + e, MAXV);
        oo = imin(m_oacc[c] + o, MAXV);
        m_freq[c] = ((m_freq[c] * ((1 << K) - 1) + ee + (1 << (K - 1))) >> K) % (MAXV + 1);
        m_duty[c] = ((m_duty[c] * ((1 << K) - 1) + oo + (1 << (K - 1))) >> K) % (MAXV + 1);
        m_minh[c] = m_hseen[c] ? m_hmin[c] : 0;
        m_maxh[c] = m_hseen[c] ? m_hmax[c] : 0;
        m_hmin[c] = 1 << 30; m_hmax[c] = 0; m_hseen[c] = 1'b0;
        m_eacc[c] = 0; m_oacc[c] = 0;
      end else begin
        m_eacc[c] = imin(m_eacc[c] + e, MAXV);
        m_oacc[c] = imin(m_oacc[c] + o, MAXV);
      end
    end
  endtask

  function automatic int exp_read(input int c, input int q);
    if (c >= NCH) return 0;
    case (q)
      0: return m_freq[c];
      1: return m_duty[c];
      2: return m_thigh[c];
      3: return m_tlow[c];
`ifdef SIGMETER_MINMAX_EN
      4: return m_minh[c];
      5: return m_maxh[c];
`endif
      default: return 0;
    endcase
  endfunction

  // One valid word; upd after the sampling edge must reflect this word's close
  task automatic drive_word(input logic [NCH*SW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_word(d);
    check("upd_word", upd, m_close);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      s_data = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("upd_idle", upd, 0);
    end
  endtask

  task automatic read_val(input int c, input int q, output logic [CW-1:0] v);
    sel_ch = 2'(c);
    sel_q  = 3'(q);
    @(posedge clk); #1;
    v = rd_data;
  endtask

  task automatic sweep(input string tag);
    logic [CW-1:0] v;
    for (int c = 0; c <= NCH; c++)
      for (int q = 0; q < 8; q++) begin
        read_val(c, q, v);
        check($sformatf("%s_c%0d_q%0d", tag, c, q), v, exp_read(c, q));
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_rd", rd_data, 0);
    check("rst_upd", upd, 0);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [SW-1:0] rand_ch();
    logic [SW-1:0] w;
    bit lv;
    w = '0;
    case ($urandom_range(0, 3))
      0: w = SW'($urandom);
      1: w = ($urandom_range(0, 1) == 1) ? '1 : '0;
      2: begin
        lv = 1'($urandom_range(0, 1));
        for (int i = 0; i < SW; i++) begin
          if ($urandom_range(0, 7) == 0) lv = ~lv;
          w[i] = lv;
        end
      end
      default: w = SW'(1) << $urandom_range(0, SW - 1);
    endcase
    return w;
  endfunction

  function automatic logic [NCH*SW-1:0] rand_word();
    return {rand_ch(), rand_ch(), rand_ch()};
  endfunction

  logic [CW-1:0] v;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; sel_ch = '0; sel_q = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd0", rd_data, 0);
    check("rst_upd0", upd, 0);
    rst = 1'b0;
    model_reset();
    sweep("reset");

    // Square wave on ch0, ch1 held low
    for (int n = 0; n < 8; n++) begin
      drive_word({rand_ch(), 32'h0, 32'h0F0F0F0F});
      idle(1);
      if (n == 3) begin
        read_val(0, 0, v); check("sq_freq1", v, 8);
        read_val(0, 1, v); check("sq_duty1", v, 16);
      end
      sweep("square");
    end
    read_val(0, 0, v); check("sq_freq2", v, 14);
    read_val(0, 1, v); check("sq_duty2", v, 28);
    read_val(0, 2, v); check("sq_thigh", v, 4);
    read_val(0, 3, v); check("sq_tlow", v, 4);
    read_val(1, 0, v); check("sq_ch1_freq", v, 0);
    read_val(1, 1, v); check("sq_ch1_duty", v, 0);

    // Readout latency: output changes only on the edge after sel_q moves
    read_val(0, 0, v);
    sel_q = 3'd2;
    #1;
    check("lat_hold", rd_data, 14);
    @(posedge clk); #1;
    check("lat_new", rd_data, 4);

    // Pulse spanning a word boundary
    do_reset();
    drive_word({64'h0, 32'h80000000});
    read_val(0, 3, v); check("span_tlow", v, 31);
    drive_word({64'h0, 32'h00000001});
    read_val(0, 2, v); check("span_thigh", v, 2);
    drive_word('0);
    drive_word('0);
    idle(1);
    read_val(0, 0, v); check("span_freq", v, 1);
    sweep("span");

    // Run-length saturation
    do_reset();
    for (int n = 0; n < 9; n++) drive_word({rand_ch(), rand_ch(), 32'hFFFFFFFF});
    drive_word({rand_ch(), rand_ch(), 32'h0});
    idle(1);
    read_val(0, 2, v); check("sat_thigh", v, MAXV);
    read_val(0, 3, v); check("sat_tlow", v, 0);
    sweep("sat");

    // Reset mid-window, then a full fresh window
    do_reset();
    drive_word(rand_word());
    drive_word(rand_word());
    do_reset();
    sweep("midrst");
    for (int n = 0; n < 4; n++) drive_word({rand_ch(), rand_ch(), 32'h0F0F0F0F});
    idle(1);
    read_val(0, 0, v); check("midrst_freq", v, 8);
    sweep("midrst2");

    // High runs 3, 7, 5 within one window, then an empty window
    do_reset();
    drive_word({64'h0, 32'h000F9FCE});
    for (int n = 0; n < 3; n++) drive_word('0);
    idle(1);
`ifdef SIGMETER_MINMAX_EN
    read_val(0, 4, v); check("mm_min", v, 3);
    read_val(0, 5, v); check("mm_max", v, 7);
`endif
    sweep("mm1");
    for (int n = 0; n < 4; n++) drive_word('0);
    idle(1);
    sweep("mm2");

    // Randomized traffic with gaps and back-to-back bursts
    do_reset();
    for (int n = 0; n < 60; n++) begin
      idle($urandom_range(0, 3));
      for (int b = 0; b < $urandom_range(1, 3); b++) drive_word(rand_word());
      idle(1);
      sweep("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
